// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong input front-end.
//   ST_00/ST_01/ST_11/ST_10 : encoder AB states, packed as {B, A}, so bit 0 is channel A
//   dir_e                   : direction result of one decoded transition
//   DEFAULT_DEBOUNCE_CYCLES : default debounce length used by the input blocks
//   step_dir()              : maps a single-bit transition to a direction, x1 or x4
package pong_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Clockwise order is 00->01->11->10->00. In x1 mode only the step back
    // into 00 counts, so one full detent cycle gives exactly one pulse.
    function automatic dir_e step_dir(input logic [1:0] prev_ab,
                                      input logic [1:0] cur_ab,
                                      input logic       x4);
        dir_e d;
        d = DIR_NONE;
        case ({prev_ab, cur_ab})
            {ST_00, ST_01}, {ST_01, ST_11}, {ST_11, ST_10}: d = x4 ? DIR_UP : DIR_NONE;
            {ST_10, ST_00}:                                 d = DIR_UP;
            {ST_00, ST_10}, {ST_10, ST_11}, {ST_11, ST_01}: d = x4 ? DIR_DOWN : DIR_NONE;
            {ST_01, ST_00}:                                 d = DIR_DOWN;
            default:                                        d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: synchroniser plus debounce filter for one encoder channel.
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   pin        in  raw asynchronous pad level
//   prime      in  load stable directly from the synchroniser output (one cycle)
//   en         in  debounce filter running (after priming)
//   sync_level out synchroniser output, used by the parent for its own priming load
//   stable     out debounced level
module input_debounce
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic prime,
    input  logic en,
    output logic sync_level,
    output logic stable
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign stable     = stable_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (prime) begin
            stable_d = sync_level;
            cnt_d    = '0;
        end else if (en) begin
            if (sync_level != stable_q) begin
                // Accept only once the mismatch has been seen on DEBOUNCE_CYCLES
                // consecutive edges; any agreeing cycle in between restarts the count.
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync_level;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_encoder_input.sv
// quad_encoder_input: one player's rotary-encoder front-end for the pong core.
// Synchronises and debounces channels A and B, decodes the Gray sequence into
// single-cycle up/down pulses, keeps a wrapping position and flags double-bit jumps.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   enc_a  in  raw encoder channel A
//   enc_b  in  raw encoder channel B
//   up     out one-cycle pulse per clockwise step
//   down   out one-cycle pulse per counter-clockwise step
//   err    out one-cycle pulse when A and B change in the same accepted update
//   pos    out wrapping position count (+1 on up, -1 on down)
// Build option: define QUAD_X4_EN to count every single-bit transition (4 per
// detent cycle); undefined, only 10->00 (up) and 01->00 (down) count.
module quad_encoder_input
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int POS_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    output logic                 up,
    output logic                 down,
    output logic                 err,
    output logic [POS_WIDTH-1:0] pos
);

`ifdef QUAD_X4_EN
    localparam logic X4_MODE = 1'b1;
`else
    localparam logic X4_MODE = 1'b0;
`endif

    localparam int               PRIME_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

    logic [PRIME_W-1:0]   prime_cnt_q, prime_cnt_d;
    logic                 primed_q, primed_d;
    logic                 prime;
    logic [1:0]           prev_q, prev_d;
    logic                 up_q, up_d;
    logic                 down_q, down_d;
    logic                 err_q, err_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    logic                 a_sync, b_sync;
    logic                 a_stable, b_stable;
    logic [1:0]           stable_ab;
    dir_e                 dir;

    input_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk       (clk),
        .reset     (reset),
        .pin       (enc_a),
        .prime     (prime),
        .en        (primed_q),
        .sync_level(a_sync),
        .stable    (a_stable)
    );

    input_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk       (clk),
        .reset     (reset),
        .pin       (enc_b),
        .prime     (prime),
        .en        (primed_q),
        .sync_level(b_sync),
        .stable    (b_stable)
    );

    assign stable_ab = {b_stable, a_stable};

    // Wait until the synchronisers hold real pin levels, then adopt them as
    // both the stable and previous state so the initial pin position is silent.
    always_comb begin
        prime       = 1'b0;
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (!primed_q) begin
            if (prime_cnt_q == PRIME_LAST) begin
                prime    = 1'b1;
                primed_d = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        prev_d = prev_q;
        up_d   = 1'b0;
        down_d = 1'b0;
        err_d  = 1'b0;
        pos_d  = pos_q;
        dir    = DIR_NONE;
        if (prime) begin
            prev_d = {b_sync, a_sync};
        end else if (primed_q) begin
            prev_d = stable_ab;
            // Both channels accepted on the same edge: direction is unknowable.
            if ((prev_q ^ stable_ab) == 2'b11) begin
                err_d = 1'b1;
            end else begin
                dir = step_dir(prev_q, stable_ab, X4_MODE);
                case (dir)
                    DIR_UP: begin
                        up_d  = 1'b1;
                        pos_d = pos_q + 1'b1;
                    end
                    DIR_DOWN: begin
                        down_d = 1'b1;
                        pos_d  = pos_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            prev_q      <= 2'b00;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            err_q       <= 1'b0;
            pos_q       <= '0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            prev_q      <= prev_d;
            up_q        <= up_d;
            down_q      <= down_d;
            err_q       <= err_d;
            pos_q       <= pos_d;
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign err  = err_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_quad_encoder_input.sv
// tb_quad_encoder_input: directed bench for quad_encoder_input with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, POS_WIDTH=4. Expected values cover both the
// default x1 build and a build with QUAD_X4_EN defined.
// Latency index k counts posedges after a pin change, the sampling edge being k=1.
module tb_quad_encoder_input;

`ifdef QUAD_X4_EN
    localparam bit X4 = 1'b1;
`else
    localparam bit X4 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       up;
    logic       down;
    logic       err;
    logic [3:0] pos;

    int n_chk = 0;
    int n_bad = 0;

    int cnt_up, cnt_dn, cnt_err, first_at, width_bad;
    logic pu, pd, pe;

    always #5 clk = ~clk;

    quad_encoder_input #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .POS_WIDTH      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .up   (up),
        .down (down),
        .err  (err),
        .pos  (pos)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_up = 0; cnt_dn = 0; cnt_err = 0; first_at = 0; width_bad = 0;
        pu = 1'b0; pd = 1'b0; pe = 1'b0;
    endtask

    task automatic sample(input int k);
        @(posedge clk);
        #1;
        if (up)   cnt_up++;
        if (down) cnt_dn++;
        if (err)  cnt_err++;
        if ((up || down || err) && first_at == 0) first_at = k;
        if ((up && pu) || (down && pd) || (err && pe) || (up && down)) width_bad++;
        pu = up; pd = down; pe = err;
    endtask

    task automatic step(input logic [1:0] ab, input int hold);
        clear_counts();
        @(negedge clk);
        {enc_b, enc_a} = ab;
        for (int k = 1; k <= hold; k++) sample(k);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        reset = 1'b1;
        {enc_b, enc_a} = ab;
        repeat (3) @(negedge clk);
        chk("rst_up", up, 0);
        chk("rst_down", down, 0);
        chk("rst_err", err, 0);
        chk("rst_pos", pos, 0);
        reset = 1'b0;
    endtask

    logic [1:0] cw [4];
    int   n_steps;
    int   total_up;
    int   total_wb;
    bit   seen;

    initial begin
        cw[0] = 2'b01; cw[1] = 2'b11; cw[2] = 2'b10; cw[3] = 2'b00;
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;

        // 1: pins high through reset, no pulses after release
        do_reset(2'b11);
        step(2'b11, 20);
        chk("t1_up", cnt_up, 0);
        chk("t1_down", cnt_dn, 0);
        chk("t1_err", cnt_err, 0);
        chk("t1_pos", pos, 0);

        // 2: clockwise detent cycle
        do_reset(2'b00);
        step(2'b00, 10);
        step(2'b01, 8);
        chk("t2_s1_up", cnt_up, X4 ? 1 : 0);
        chk("t2_s1_lat", first_at, X4 ? 7 : 0);
        step(2'b11, 8);
        chk("t2_s2_up", cnt_up, X4 ? 1 : 0);
        chk("t2_s2_wb", width_bad, 0);
        step(2'b10, 8);
        chk("t2_s3_up", cnt_up, X4 ? 1 : 0);
        step(2'b00, 8);
        chk("t2_s4_up", cnt_up, 1);
        chk("t2_s4_lat", first_at, 7);
        chk("t2_s4_wb", width_bad, 0);
        chk("t2_s4_down", cnt_dn, 0);
        chk("t2_pos", pos, X4 ? 4 : 1);

        // 3: reverse detent cycle
        step(2'b10, 8);
        chk("t3_s1_down", cnt_dn, X4 ? 1 : 0);
        step(2'b11, 8);
        chk("t3_s2_down", cnt_dn, X4 ? 1 : 0);
        step(2'b01, 8);
        chk("t3_s3_down", cnt_dn, X4 ? 1 : 0);
        step(2'b00, 8);
        chk("t3_s4_down", cnt_dn, 1);
        chk("t3_s4_up", cnt_up, 0);
        chk("t3_s4_lat", first_at, 7);
        chk("t3_pos", pos, 0);

        // 4a: three-cycle glitch on A is never accepted
        clear_counts();
        @(negedge clk); enc_a = 1'b1;
        for (int k = 1; k <= 3; k++) sample(k);
        @(negedge clk); enc_a = 1'b0;
        for (int k = 4; k <= 15; k++) sample(k);
        chk("t4_glitch_pulses", cnt_up + cnt_dn + cnt_err, 0);
        chk("t4_glitch_pos", pos, 0);

        // 4b: A bounces 1,0 then settles at 1; only the settled level counts
        clear_counts();
        @(negedge clk); enc_a = 1'b1; sample(1);
        @(negedge clk); enc_a = 1'b0; sample(2);
        @(negedge clk); enc_a = 1'b1;
        for (int k = 3; k <= 14; k++) sample(k);
        chk("t4_bounce_up", cnt_up, X4 ? 1 : 0);
        chk("t4_bounce_down", cnt_dn, 0);
        chk("t4_bounce_lat", first_at, X4 ? 9 : 0);
        chk("t4_bounce_pos", pos, X4 ? 1 : 0);
        step(2'b00, 8);
        chk("t4_back_down", cnt_dn, 1);
        chk("t4_back_pos", pos, X4 ? 0 : 15);

        // 5: both channels together
        step(2'b11, 10);
        chk("t5_err", cnt_err, 1);
        chk("t5_updown", cnt_up + cnt_dn, 0);
        chk("t5_lat", first_at, 7);
        chk("t5_wb", width_bad, 0);
        chk("t5_pos", pos, X4 ? 0 : 15);
        step(2'b00, 10);
        chk("t5_err_back", cnt_err, 1);
        chk("t5_pos_back", pos, X4 ? 0 : 15);

        // 6: seventeen clockwise counts wrap the 4-bit position
        do_reset(2'b00);
        step(2'b00, 10);
        n_steps  = X4 ? 17 : 68;
        total_up = 0;
        total_wb = 0;
        for (int i = 0; i < n_steps; i++) begin
            step(cw[i % 4], 8);
            total_up += cnt_up;
            total_wb += width_bad;
        end
        chk("t6_ups", total_up, 17);
        chk("t6_wb", total_wb, 0);
        chk("t6_pos_wrap", pos, 1);

        // 6b: reset while an up pulse is high
        seen = 1'b0;
        for (int i = n_steps; i < n_steps + 4 && !seen; i++) begin
            @(negedge clk);
            {enc_b, enc_a} = cw[i % 4];
            for (int k = 0; k < 8 && !seen; k++) begin
                @(posedge clk);
                #1;
                if (up) seen = 1'b1;
            end
        end
        chk("t6_pulse_seen", seen, 1);
        chk("t6_pos_pre", pos, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_up", up, 0);
        chk("t6_rst_pos", pos, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
